// File: rtl/seqdet_arbiter_if.sv
// Bundle of requester-side and detector-side signals around the shared sequence detector.
// The master modport belongs to the arbiter; the slave modport belongs to the requesters and the detector.
interface seqdet_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8
);
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] bit_in;
  logic [N_REQ-1:0] gnt;
  logic             bit_take;
  logic             det_a;
  logic             det_clr;
  logic             det_mealy;
  logic             det_moore;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [CW-1:0]    mealy_cnt;
  logic [CW-1:0]    moore_cnt;

  modport master (
    input  req, bit_in, det_mealy, det_moore,
    output gnt, bit_take, det_a, det_clr, busy, done, done_id, mealy_cnt, moore_cnt
  );

  modport slave (
    output req, bit_in, det_mealy, det_moore,
    input  gnt, bit_take, det_a, det_clr, busy, done, done_id, mealy_cnt, moore_cnt
  );
endinterface

// File: rtl/seqdet_arbiter.sv
// Round-robin owner of a shared serial sequence detector: clears it, streams one frame from
// the granted requester, counts Mealy/Moore hits (Moore one cycle late) and reports them.
module seqdet_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                 clck,
  input  logic                 ares,
  seqdet_arbiter_if.master     bus
);
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, REPORT} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             det_clr_q, det_clr_d;
  logic [CW-1:0]    mealy_cnt_q, mealy_cnt_d;
  logic [CW-1:0]    moore_cnt_q, moore_cnt_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    mealy_acc_q, mealy_acc_d;
  logic [CW-1:0]    moore_acc_q, moore_acc_d;

  logic [IDW-1:0]   hi_idx, lo_idx, win_idx;
  logic             hi_found, win_any;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_idx   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    win_any = |bus.req;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    done_id_d   = done_id_q;
    gnt_d       = gnt_q;
    det_clr_d   = 1'b0;
    mealy_cnt_d = mealy_cnt_q;
    moore_cnt_d = moore_cnt_q;
    k_d         = k_q;
    mealy_acc_d = mealy_acc_q;
    moore_acc_d = moore_acc_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          owner_d   = win_idx;
          gnt_d     = N_REQ'(1) << win_idx;
          det_clr_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        k_d         = '0;
        mealy_acc_d = '0;
        moore_acc_d = '0;
        state_d     = STREAM;
      end
      STREAM: begin
        mealy_acc_d = mealy_acc_q + CW'(bus.det_mealy);
        // det_moore at k=0 still reflects the cleared detector, not a frame bit.
        if (k_q != '0) moore_acc_d = moore_acc_q + CW'(bus.det_moore);
        k_d = k_q + CW'(1);
        if (k_q == CW'(FRAME_LEN - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        gnt_d       = '0;
        done_id_d   = owner_q;
        mealy_cnt_d = mealy_acc_q;
        moore_cnt_d = moore_acc_q + CW'(bus.det_moore);
        state_d     = REPORT;
      end
      REPORT: begin
        ptr_d   = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (ares) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      done_id_q   <= '0;
      gnt_q       <= '0;
      det_clr_q   <= 1'b0;
      mealy_cnt_q <= '0;
      moore_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      done_id_q   <= done_id_d;
      gnt_q       <= gnt_d;
      det_clr_q   <= det_clr_d;
      mealy_cnt_q <= mealy_cnt_d;
      moore_cnt_q <= moore_cnt_d;
    end
  end

  always_ff @(posedge clck) begin
    k_q         <= k_d;
    mealy_acc_q <= mealy_acc_d;
    moore_acc_q <= moore_acc_d;
  end

  assign bus.gnt       = gnt_q;
  assign bus.det_clr   = det_clr_q;
  assign bus.bit_take  = (state_q == STREAM);
  assign bus.det_a     = (state_q == STREAM) & bus.bit_in[owner_q];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == REPORT);
  assign bus.done_id   = done_id_q;
  assign bus.mealy_cnt = mealy_cnt_q;
  assign bus.moore_cnt = moore_cnt_q;
endmodule

// File: tb/tb_seqdet_arbiter.sv
// Bench for seqdet_arbiter: detector stub, per-requester frame sources, and a scoreboard of
// expected reports (owner, counts, cycle) compared whenever done pulses.
module tb_seqdet_arbiter;
  localparam int N_REQ     = 4;
  localparam int FRAME_LEN = 8;

  logic clck = 1'b0;
  logic ares;
  int   cyc = 0;

  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  seqdet_arbiter_if #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN)) bus ();

  seqdet_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN)) dut (
    .clck (clck),
    .ares (ares),
    .bus  (bus)
  );

  // Detector stub: Mealy follows det_a, Moore is det_a one cycle later, cleared by det_clr.
  logic moore_q;
  always @(posedge clck) moore_q <= bus.det_clr ? 1'b0 : bus.det_a;
  assign bus.det_mealy = bus.det_a;
  assign bus.det_moore = moore_q;

  // Frame sources, MSB first; the owner advances on each bit_take edge.
  logic [7:0] pat [N_REQ];
  logic [2:0] pos [N_REQ];
  always @(posedge clck) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (ares || (bus.det_clr && bus.gnt[i])) pos[i] <= 3'd0;
      else if (bus.bit_take && bus.gnt[i])     pos[i] <= pos[i] + 3'd1;
    end
  end
  always_comb begin
    bus.bit_in = '0;
    for (int i = 0; i < N_REQ; i++) bus.bit_in[i] = pat[i][3'd7 - pos[i]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int id;
    int mc;
    int oc;
    int at;
  } exp_t;
  exp_t exp_q [$];
  int   done_cnt = 0;

  task automatic push_exp(input int id, input int at);
    exp_t e;
    e.id = id;
    e.mc = $countones(pat[id]);
    e.oc = $countones(pat[id]);
    e.at = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clck) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("done_id",    32'(bus.done_id),   32'(e.id));
        check_val("mealy_cnt",  32'(bus.mealy_cnt), 32'(e.mc));
        check_val("moore_cnt",  32'(bus.moore_cnt), 32'(e.oc));
        check_val("done_cycle", 32'(cyc),           32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic wait_dones(input int target);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt >= target) break;
      tick();
    end
    check_val("wait_done", 32'(done_cnt >= target), 32'd1);
  endtask

  int c0;

  initial begin
    ares    = 1'b1;
    bus.req = 4'b1111;
    pat[0]  = 8'b1011_0010;
    pat[1]  = 8'b1110_0111;
    pat[2]  = 8'b1011_0010;
    pat[3]  = 8'b0000_0001;
    tick();
    tick();

    check_val("rst_gnt",       32'(bus.gnt),       32'd0);
    check_val("rst_busy",      32'(bus.busy),      32'd0);
    check_val("rst_done",      32'(bus.done),      32'd0);
    check_val("rst_det_clr",   32'(bus.det_clr),   32'd0);
    check_val("rst_bit_take",  32'(bus.bit_take),  32'd0);
    check_val("rst_done_id",   32'(bus.done_id),   32'd0);
    check_val("rst_mealy_cnt", 32'(bus.mealy_cnt), 32'd0);
    check_val("rst_moore_cnt", 32'(bus.moore_cnt), 32'd0);

    // Round robin with all requesters held: owners 0,1,2,3,0 every 12 cycles.
    ares = 1'b0;
    c0   = cyc + 1;
    for (int n = 0; n < 5; n++) push_exp(n % N_REQ, c0 + 12 * n + 10);
    tick();
    check_val("clear_gnt",      32'(bus.gnt),      32'b0001);
    check_val("clear_det_clr",  32'(bus.det_clr),  32'd1);
    check_val("clear_busy",     32'(bus.busy),     32'd1);
    check_val("clear_bit_take", 32'(bus.bit_take), 32'd0);
    for (int k = 0; k < FRAME_LEN; k++) begin
      tick();
      check_val("stream_bit_take", 32'(bus.bit_take), 32'd1);
      check_val("stream_det_clr",  32'(bus.det_clr),  32'd0);
      check_val("stream_gnt",      32'(bus.gnt),      32'b0001);
      check_val("stream_det_a",    32'(bus.det_a),    32'(pat[0][7 - k]));
    end
    tick();
    check_val("drain_gnt",      32'(bus.gnt),      32'b0001);
    check_val("drain_bit_take", 32'(bus.bit_take), 32'd0);
    check_val("drain_det_a",    32'(bus.det_a),    32'd0);
    tick();
    check_val("report_gnt",  32'(bus.gnt),  32'd0);
    check_val("report_done", 32'(bus.done), 32'd1);
    wait_dones(5);
    bus.req = 4'b0000;

    // Single frame from requester 2.
    tick();
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0100;
    c0 = cyc + 1;
    push_exp(2, c0 + 10);
    tick();
    check_val("single_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    wait_dones(6);
    check_val("cnt_hold",   32'(bus.mealy_cnt), 32'd4);
    check_val("done_pulse", 32'(bus.done),      32'd0);

    // Serve owner 3, then 1001 must wrap to 0 before returning to 3.
    bus.req = 4'b1000;
    c0 = cyc + 1;
    push_exp(3, c0 + 10);
    tick();
    bus.req = 4'b0000;
    wait_dones(7);
    bus.req = 4'b1001;
    c0 = cyc + 1;
    push_exp(0, c0 + 10);
    push_exp(3, c0 + 22);
    wait_dones(9);
    bus.req = 4'b0000;

    // Owner 1 drops its request during STREAM k=3; the frame still completes.
    bus.req = 4'b0010;
    c0 = cyc + 1;
    push_exp(1, c0 + 10);
    repeat (5) tick();
    check_val("drop_bit_take", 32'(bus.bit_take), 32'd1);
    bus.req = 4'b0000;
    wait_dones(10);

    // Reset during STREAM k=5 discards the frame and the round-robin pointer.
    bus.req = 4'b0100;
    c0 = cyc + 1;
    repeat (7) tick();
    check_val("abort_gnt_pre", 32'(bus.gnt), 32'b0100);
    ares    = 1'b1;
    bus.req = 4'b0000;
    tick();
    check_val("abort_gnt",      32'(bus.gnt),      32'd0);
    check_val("abort_busy",     32'(bus.busy),     32'd0);
    check_val("abort_done",     32'(bus.done),     32'd0);
    check_val("abort_bit_take", 32'(bus.bit_take), 32'd0);
    ares = 1'b0;
    repeat (15) tick();
    check_val("abort_no_done", 32'(done_cnt), 32'd10);
    bus.req = 4'b1010;
    c0 = cyc + 1;
    push_exp(1, c0 + 10);
    tick();
    check_val("restart_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0000;
    wait_dones(11);
    repeat (4) tick();
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
